// File: rtl/sdram_port_resp.sv
// rtl/sdram_port_resp.sv - 32-bit request port responder issuing two 16-bit beats on a halfword memory bus
// Optional last-read tag short-circuit enabled by defining SDRAM_PORT_RDCACHE_EN.
module sdram_port_resp #(
   parameter int RD_LAT = 2,
   parameter int AW     = 25
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic [AW-1:0] WADDR,
   input  logic [31:0]   DIN,
   input  logic [3:0]    BE,
   input  logic          WE,
   output logic          WE_RDY,
   input  logic [AW-1:0] RADDR,
   input  logic          RD,
   output logic          RD_RDY,
   output logic [31:0]   DOUT,
   output logic [AW-2:0] MEM_A,
   output logic          MEM_RD,
   output logic          MEM_WE,
   output logic [1:0]    MEM_BE,
   output logic [15:0]   MEM_DI,
   input  logic [15:0]   MEM_DO
);

   typedef enum logic [2:0] {IDLE, WB0, WB1, RB0, RB1, RWAIT} state_t;

   localparam logic [AW-2:0] ONE_H = 1;

   state_t            state;
   logic [AW-2:0]     wr_h;
   logic [AW-2:0]     rd_h;
   logic [AW-2:0]     hi_a;
   logic [15:0]       hi_di;
   logic [1:0]        hi_be;
   logic [RD_LAT-1:0] pipe_v;
   logic [RD_LAT-1:0] pipe_b;
   logic              cap_v;
   logic              cap_b;
   logic              last_cap;
   logic              rwait_done;
   logic              rd_hit;
   logic              addr_lsb_unused;

   assign wr_h            = WADDR[AW-1:1];
   assign rd_h            = RADDR[AW-1:1];
   assign addr_lsb_unused = WADDR[0] ^ RADDR[0];
   assign cap_v           = pipe_v[RD_LAT-1];
   assign cap_b           = pipe_b[RD_LAT-1];
   assign last_cap        = cap_v & cap_b;

`ifdef SDRAM_PORT_RDCACHE_EN
   logic          tag_v;
   logic          hit_q;
   logic [AW-2:0] tag_h;
   logic [AW-2:0] rd_base;
   logic          wr_hits_tag;

   assign rd_hit      = tag_v && (rd_h == tag_h);
   // A write covers H and H+1; any overlap with the cached pair stales the tag.
   assign wr_hits_tag = (wr_h == tag_h) || (wr_h == tag_h + ONE_H) || (wr_h + ONE_H == tag_h);
   assign rwait_done  = last_cap || hit_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         tag_v   <= 1'b0;
         hit_q   <= 1'b0;
         tag_h   <= '0;
         rd_base <= '0;
      end else begin
         hit_q <= (state == IDLE) && !WE && RD && rd_hit;
         if (state == IDLE && !WE && RD)
            rd_base <= rd_h;
         if (state == IDLE && WE && wr_hits_tag)
            tag_v <= 1'b0;
         else if (state == RWAIT && last_cap) begin
            tag_v <= 1'b1;
            tag_h <= rd_base;
         end
      end
   end
`else
   assign rd_hit     = 1'b0;
   assign rwait_done = last_cap;
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state  <= IDLE;
         WE_RDY <= 1'b1;
         RD_RDY <= 1'b1;
         DOUT   <= '0;
         MEM_RD <= 1'b0;
         MEM_WE <= 1'b0;
         MEM_A  <= '0;
         MEM_BE <= '0;
         MEM_DI <= '0;
         hi_a   <= '0;
         hi_di  <= '0;
         hi_be  <= '0;
         pipe_v <= '0;
         pipe_b <= '0;
      end else begin
         // The state names the beat currently on the bus, so RB1 marks a beat-1 issue.
         pipe_v[0] <= MEM_RD;
         pipe_b[0] <= (state == RB1);
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_b[i] <= pipe_b[i-1];
         end

         if (cap_v) begin
            if (cap_b)
               DOUT[31:16] <= MEM_DO;
            else
               DOUT[15:0]  <= MEM_DO;
         end

         case (state)
            IDLE: begin
               if (WE) begin
                  MEM_A  <= wr_h;
                  MEM_DI <= DIN[15:0];
                  MEM_BE <= BE[1:0];
                  MEM_WE <= |BE[1:0];
                  hi_a   <= wr_h + ONE_H;
                  hi_di  <= DIN[31:16];
                  hi_be  <= BE[3:2];
                  WE_RDY <= 1'b0;
                  RD_RDY <= 1'b0;
                  state  <= WB0;
               end else if (RD) begin
                  WE_RDY <= 1'b0;
                  RD_RDY <= 1'b0;
                  if (rd_hit) begin
                     state <= RWAIT;
                  end else begin
                     MEM_A  <= rd_h;
                     MEM_RD <= 1'b1;
                     hi_a   <= rd_h + ONE_H;
                     state  <= RB0;
                  end
               end
            end
            WB0: begin
               MEM_A  <= hi_a;
               MEM_DI <= hi_di;
               MEM_BE <= hi_be;
               MEM_WE <= |hi_be;
               state  <= WB1;
            end
            WB1: begin
               MEM_WE <= 1'b0;
               WE_RDY <= 1'b1;
               RD_RDY <= 1'b1;
               state  <= IDLE;
            end
            RB0: begin
               MEM_A <= hi_a;
               state <= RB1;
            end
            RB1: begin
               MEM_RD <= 1'b0;
               state  <= RWAIT;
            end
            RWAIT: begin
               if (rwait_done) begin
                  WE_RDY <= 1'b1;
                  RD_RDY <= 1'b1;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_port_resp.sv
// tb/tb_sdram_port_resp.sv - directed vector bench for sdram_port_resp with a fixed-latency halfword RAM model
module tb_sdram_port_resp;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [24:0] WADDR = '0;
   logic [31:0] DIN = '0;
   logic [3:0]  BE = '0;
   logic        WE = 1'b0;
   logic        WE_RDY;
   logic [24:0] RADDR = '0;
   logic        RD = 1'b0;
   logic        RD_RDY;
   logic [31:0] DOUT;
   logic [23:0] MEM_A;
   logic        MEM_RD;
   logic        MEM_WE;
   logic [1:0]  MEM_BE;
   logic [15:0] MEM_DI;
   logic [15:0] MEM_DO = '0;

   int n_vec = 0;
   int n_bad = 0;

   sdram_port_resp #(.RD_LAT(2), .AW(25)) dut (
      .CLK(CLK), .RST(RST),
      .WADDR(WADDR), .DIN(DIN), .BE(BE), .WE(WE), .WE_RDY(WE_RDY),
      .RADDR(RADDR), .RD(RD), .RD_RDY(RD_RDY), .DOUT(DOUT),
      .MEM_A(MEM_A), .MEM_RD(MEM_RD), .MEM_WE(MEM_WE), .MEM_BE(MEM_BE),
      .MEM_DI(MEM_DI), .MEM_DO(MEM_DO)
   );

   always #5 CLK = ~CLK;

   // Halfword RAM, 2-cycle read latency; low 10 address bits suffice for the addresses used.
   logic [15:0] mem [0:1023];
   logic [9:0]  a_q = '0;
   always @(posedge CLK) begin
      a_q    <= MEM_A[9:0];
      MEM_DO <= mem[a_q];
      if (MEM_WE)
         mem[MEM_A[9:0]] <= {MEM_BE[1] ? MEM_DI[15:8] : mem[MEM_A[9:0]][15:8],
                             MEM_BE[0] ? MEM_DI[7:0]  : mem[MEM_A[9:0]][7:0]};
   end

   typedef struct {
      bit          wr;
      bit          hit;
      logic [24:0] addr;
      logic [31:0] din;
      logic [3:0]  be;
      logic [31:0] exp_dout;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_vec(input vec_t v);
      logic [23:0] h;
      logic [23:0] h1;
      h  = v.addr[24:1];
      h1 = h + 24'd1;
      @(negedge CLK);
      chk("idle_rdy", {30'd0, WE_RDY, RD_RDY}, 32'd3);
      if (v.wr) begin
         WADDR = v.addr; DIN = v.din; BE = v.be; WE = 1'b1;
      end else begin
         RADDR = v.addr; BE = v.be; RD = 1'b1;
      end
      next_cycle();
      WE = 1'b0;
      RD = 1'b0;
      if (v.wr) begin
         chk("wr_b0_we", 32'(MEM_WE), 32'(|v.be[1:0]));
         chk("wr_b0_a", 32'(MEM_A), 32'(h));
         if (|v.be[1:0]) begin
            chk("wr_b0_di", 32'(MEM_DI), 32'(v.din[15:0]));
            chk("wr_b0_be", 32'(MEM_BE), 32'(v.be[1:0]));
         end
         chk("wr_b0_rdy", 32'(WE_RDY), 32'd0);
         next_cycle();
         chk("wr_b1_we", 32'(MEM_WE), 32'(|v.be[3:2]));
         chk("wr_b1_a", 32'(MEM_A), 32'(h1));
         if (|v.be[3:2]) begin
            chk("wr_b1_di", 32'(MEM_DI), 32'(v.din[31:16]));
            chk("wr_b1_be", 32'(MEM_BE), 32'(v.be[3:2]));
         end
         next_cycle();
         chk("wr_done_rdy", {30'd0, WE_RDY, RD_RDY}, 32'd3);
         chk("wr_done_we", 32'(MEM_WE), 32'd0);
      end else if (v.hit) begin
         chk("hit_rdy_lo", 32'(RD_RDY), 32'd0);
         chk("hit_no_rd", 32'(MEM_RD), 32'd0);
         next_cycle();
         chk("hit_rdy", 32'(RD_RDY), 32'd1);
         chk("hit_no_rd2", 32'(MEM_RD), 32'd0);
         chk("hit_dout", DOUT, v.exp_dout);
      end else begin
         chk("rd_b0_rd", 32'(MEM_RD), 32'd1);
         chk("rd_b0_a", 32'(MEM_A), 32'(h));
         chk("rd_b0_we", 32'(MEM_WE), 32'd0);
         next_cycle();
         chk("rd_b1_rd", 32'(MEM_RD), 32'd1);
         chk("rd_b1_a", 32'(MEM_A), 32'(h1));
         next_cycle();
         chk("rd_t3_rdy", {30'd0, RD_RDY, MEM_RD}, 32'd0);
         next_cycle();
         chk("rd_t4_rdy", 32'(RD_RDY), 32'd0);
         next_cycle();
         chk("rd_t5_rdy", 32'(RD_RDY), 32'd1);
         chk("rd_dout", DOUT, v.exp_dout);
      end
   endtask

   initial begin
      logic strobe_seen;
      bit   cache_on;
`ifdef SDRAM_PORT_RDCACHE_EN
      cache_on = 1'b1;
`else
      cache_on = 1'b0;
`endif
      for (int i = 0; i < 1024; i++) mem[i] = '0;

      vecs[0] = '{1'b1, 1'b0,     25'h0000100, 32'hDEADBEEF, 4'hF,    32'h0};
      vecs[1] = '{1'b0, 1'b0,     25'h0000101, 32'h0,        4'h0,    32'hDEADBEEF};
      vecs[2] = '{1'b1, 1'b0,     25'h0000200, 32'h0000AB00, 4'b0010, 32'h0};
      vecs[3] = '{1'b0, 1'b0,     25'h0000200, 32'h0,        4'hF,    32'h0000AB00};
      vecs[4] = '{1'b1, 1'b0,     25'h1FFFFFE, 32'h12345678, 4'hF,    32'h0};
      vecs[5] = '{1'b0, 1'b0,     25'h0000100, 32'h0,        4'hF,    32'hDEADBEEF};
      vecs[6] = '{1'b0, cache_on, 25'h0000100, 32'h0,        4'hF,    32'hDEADBEEF};
      vecs[7] = '{1'b1, 1'b0,     25'h0000102, 32'h55556666, 4'hF,    32'h0};
      vecs[8] = '{1'b0, 1'b0,     25'h0000100, 32'h0,        4'hF,    32'h6666BEEF};

      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      chk("rst_rdy", {30'd0, WE_RDY, RD_RDY}, 32'd3);
      chk("rst_dout", DOUT, 32'h0);
      chk("rst_mem", {MEM_A, MEM_BE, MEM_RD, MEM_WE}, 32'h0);
      chk("rst_di", 32'(MEM_DI), 32'h0);
      strobe_seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         strobe_seen = strobe_seen | MEM_RD | MEM_WE | !WE_RDY | !RD_RDY;
      end
      chk("idle_20", 32'(strobe_seen), 32'd0);

      for (int i = 0; i < 5; i++) do_vec(vecs[i]);

      // Read of the top halfword wraps beat 1 to 0, then reset lands mid-flight.
      @(negedge CLK);
      RADDR = 25'h1FFFFFE;
      RD = 1'b1;
      next_cycle();
      RD = 1'b0;
      chk("wrap_b0_a", 32'(MEM_A), 32'h00FFFFFF);
      next_cycle();
      chk("wrap_b1_a", 32'(MEM_A), 32'h0);
      chk("wrap_b1_rd", 32'(MEM_RD), 32'd1);
      RST = 1'b1;
      #1;
      chk("mid_rst_rdy", {30'd0, WE_RDY, RD_RDY}, 32'd3);
      chk("mid_rst_dout", DOUT, 32'h0);
      chk("mid_rst_rd", 32'(MEM_RD), 32'd0);
      @(negedge CLK);
      RST = 1'b0;
      strobe_seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         strobe_seen = strobe_seen | MEM_RD | MEM_WE | (DOUT != 32'h0);
      end
      chk("late_return_dropped", 32'(strobe_seen), 32'd0);
      chk("late_dout", DOUT, 32'h0);

      for (int i = 5; i < 9; i++) do_vec(vecs[i]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
